// File: rtl/memory_loader_pkg.sv
// +----------------------------------------------------------------------------
// | memory_loader_pkg : shared states and frame constants for the operand path
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

package memory_loader_pkg;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 5;
  localparam int FILTER_BASE = 16;
  localparam int FRAME_LEN   = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } ml_state_t;

endpackage

`default_nettype wire

// File: rtl/memory_loader_fsm.sv
// +----------------------------------------------------------------------------
// | memory_loader_fsm : frame state, element count, ready and abort decisions
// | Optional CHECK state under MEMORY_LOADER_CHECKSUM_EN
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module memory_loader_fsm #(
  parameter int ADDR_W    = memory_loader_pkg::ADDR_W,
  parameter int LAST_ADDR = memory_loader_pkg::FRAME_LEN - 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  input  logic              i_sof,
  input  logic              i_busy,
`ifdef MEMORY_LOADER_CHECKSUM_EN
  input  logic              i_sum_ok,
`endif
  output logic              o_ready,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_done,
  output logic              o_abort
);
  import memory_loader_pkg::*;

  ml_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_count, w_count_nxt;
  logic              w_accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    o_ready     = !i_busy && (r_state != ST_DONE);
    w_accept    = i_valid && o_ready;
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    o_write     = 1'b0;
    o_addr      = r_count;
    o_done      = (r_state == ST_DONE);
    o_abort     = 1'b0;

    if (w_accept && i_sof) begin
      // A new start of frame always restarts at the tile origin
      o_write     = 1'b1;
      o_addr      = '0;
      w_count_nxt = ADDR_W'(1);
      w_state_nxt = ST_LOAD;
      o_abort     = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    end else if (w_accept) begin
      case (r_state)
        ST_LOAD: begin
          o_write = 1'b1;
          if (r_count == ADDR_W'(LAST_ADDR)) begin
            w_count_nxt = '0;
`ifdef MEMORY_LOADER_CHECKSUM_EN
            w_state_nxt = ST_CHECK;
`else
            w_state_nxt = ST_DONE;
`endif
          end else begin
            w_count_nxt = r_count + ADDR_W'(1);
          end
        end
`ifdef MEMORY_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          w_state_nxt = i_sum_ok ? ST_DONE : ST_IDLE;
          o_abort     = !i_sum_ok;
        end
`endif
        default: ;
      endcase
    end

    if (r_state == ST_DONE) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/memory_loader.sv
// +----------------------------------------------------------------------------
// | memory_loader : frames a byte stream into a 4x4 tile + 3x3 filter write burst
// | Optional trailing checksum byte under MEMORY_LOADER_CHECKSUM_EN
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module memory_loader #(
  parameter int DATA_W   = memory_loader_pkg::DATA_W,
  parameter int N_INPUT  = 16,
  parameter int N_FILTER = 9,
  parameter int ADDR_W   = memory_loader_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  input  logic              compute_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              load_done,
  output logic              frame_err
);

  logic              w_write;
  logic              w_abort;
  logic [ADDR_W-1:0] w_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_err;

`ifdef MEMORY_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              w_sum_ok;

  assign w_sum_ok = (r_sum == in_data);

  // Address 0 is only ever written by a start-of-frame byte, so it reseeds the sum
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_sum <= '0;
    else if (w_write)
      r_sum <= (w_addr == '0) ? in_data : r_sum + in_data;
  end
`endif

  memory_loader_fsm #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (N_INPUT + N_FILTER - 1)
  ) u_fsm (
    .clk      (clk),
    .resetn   (resetn),
    .i_valid  (in_valid),
    .i_sof    (in_sof),
    .i_busy   (compute_busy),
`ifdef MEMORY_LOADER_CHECKSUM_EN
    .i_sum_ok (w_sum_ok),
`endif
    .o_ready  (in_ready),
    .o_write  (w_write),
    .o_addr   (w_addr),
    .o_done   (load_done),
    .o_abort  (w_abort)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= w_write;
      r_err   <= w_abort;
      if (w_write) begin
        r_wr_addr <= w_addr;
        r_wr_data <= in_data;
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_memory_loader.sv
// +----------------------------------------------------------------------------
// | tb_memory_loader : scoreboard bench with a frame-level reference model
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tb_memory_loader;

  localparam int FRAME = 25;
`ifdef MEMORY_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_ready;
  logic       compute_busy = 1'b0;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       load_done;
  logic       frame_err;

  memory_loader dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_ready     (in_ready),
    .compute_busy (compute_busy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .load_done    (load_done),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         wr;
    logic [4:0] addr;
    logic [7:0] data;
    bit         done;
    bit         err;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: position inside the frame (-1 = waiting for sof)
  int         m_idx = -1;
  logic [7:0] m_sum = '0;
  bit         m_done_now = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one expectation per cycle, idle outputs when nothing is due
  always @(negedge clk) begin
    exp_t e;
    e = '{due: cyc, wr: 1'b0, addr: 5'd0, data: 8'd0, done: 1'b0, err: 1'b0};
    if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
    n_vec++;
    if (wr_en !== e.wr) begin
      n_bad++;
      $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, wr_en, e.wr);
    end
    if (e.wr && (wr_addr !== e.addr || wr_data !== e.data)) begin
      n_bad++;
      $display("FAIL write cyc=%0d got=%0d/%h exp=%0d/%h", cyc, wr_addr, wr_data, e.addr, e.data);
    end
    if (load_done !== e.done) begin
      n_bad++;
      $display("FAIL load_done cyc=%0d got=%b exp=%b", cyc, load_done, e.done);
    end
    if (frame_err !== e.err) begin
      n_bad++;
      $display("FAIL frame_err cyc=%0d got=%b exp=%b", cyc, frame_err, e.err);
    end
    if (!resetn && (wr_addr !== 5'd0 || wr_data !== 8'd0)) begin
      n_bad++;
      $display("FAIL reset_addr_data cyc=%0d got=%0d/%h exp=0/00", cyc, wr_addr, wr_data);
    end
  end

  task automatic drive(input bit v, input bit s, input logic [7:0] d, input bit b);
    exp_t e;
    bit   exp_ready, acc, nd;
    @(posedge clk); #1;
    in_valid = v; in_sof = s; in_data = d; compute_busy = b;
    #1;
    exp_ready = !b && !m_done_now;
    n_vec++;
    if (in_ready !== exp_ready) begin
      n_bad++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready);
    end
    acc = v && exp_ready;
    nd  = 1'b0;
    e   = '{due: cyc + 1, wr: 1'b0, addr: 5'd0, data: 8'd0, done: 1'b0, err: 1'b0};
    if (acc && s) begin
      e.err = (m_idx >= 0);
      e.wr = 1'b1; e.addr = 5'd0; e.data = d;
      m_idx = 1; m_sum = d;
    end else if (acc && m_idx >= 0) begin
      if (m_idx < FRAME) begin
        e.wr = 1'b1; e.addr = 5'(m_idx); e.data = d;
        m_sum = m_sum + d;
        m_idx++;
        if (m_idx == FRAME && !CHK) begin
          e.done = 1'b1; nd = 1'b1; m_idx = -1;
        end
      end else begin
        if (d == m_sum) begin
          e.done = 1'b1; nd = 1'b1;
        end else begin
          e.err = 1'b1;
        end
        m_idx = -1;
      end
    end
    m_done_now = nd;
    if (e.wr || e.done || e.err) q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    resetn = 1'b0; in_valid = 1'b0; in_sof = 1'b0; compute_busy = 1'b0;
    q.delete();
    m_idx = -1; m_done_now = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready cyc=%0d got=%b exp=1", cyc, in_ready);
    end
    repeat (n) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic frame(input logic [7:0] base);
    for (int i = 0; i < FRAME; i++) drive(1'b1, i == 0, base + 8'(i), 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Clean frame 1..25
    frame(8'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Garbage before sof, then a frame
    drive(1'b1, 1'b0, 8'hAA, 1'b0);
    drive(1'b1, 1'b0, 8'hBB, 1'b0);
    frame(8'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Busy stall after byte 10
    for (int i = 0; i < 10; i++) drive(1'b1, i == 0, 8'd1 + 8'(i), 1'b0);
    repeat (5) drive(1'b1, 1'b0, 8'd11, 1'b1);
    for (int i = 10; i < FRAME; i++) drive(1'b1, 1'b0, 8'd1 + 8'(i), 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Abort after 7 bytes, restart with 0x55
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, 8'h10 + 8'(i), 1'b0);
    frame(8'h55);
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset mid-frame after 12 bytes, then a new frame
    for (int i = 0; i < 12; i++) drive(1'b1, i == 0, 8'h30 + 8'(i), 1'b0);
    do_reset(2);
    frame(8'h70);
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    if (CHK) begin
      frame(8'd1);
      drive(1'b1, 1'b0, 8'h45, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      frame(8'd1);
      drive(1'b1, 1'b0, 8'h46, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
    end

    // Randomized traffic
    begin
      int busy_left = 0;
      for (int c = 0; c < 3000; c++) begin
        bit v, s, b;
        if (busy_left > 0) busy_left--;
        else if ($urandom_range(0, 49) == 0) busy_left = $urandom_range(1, 8);
        b = (busy_left > 0);
        v = ($urandom_range(0, 9) < 8);
        s = ($urandom_range(0, 39) == 0);
        drive(v, s, 8'($urandom), b);
      end
    end

    repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
